dcache_miss_ctrl: RTL and testbench
===================================

// Module: dcache_miss_ctrl
// PURPOSE
//  Data-cache miss sequencer in the memory stage. Drives d_cache_miss and enable_write_from_cache_to_memory into stall_control.
//  On a miss: write back the dirty victim line if needed, refill the line from main memory, then release the stall.
//  Sits between the D-cache tag/data arrays and the main-memory line interface.
// PARAMETERS
//  ADDR_W      32  byte-address width
//  DATA_W      32  word width
//  LINE_WORDS  4   words per line (power of 2, >=2)
//  (derived)   LINE_W = LINE_WORDS*DATA_W; OFFSET_W = log2(LINE_WORDS*DATA_W/8)
// PORTS
//  clk                                in   1        clock, rising edge
//  rst_n                              in   1        async active-low reset
//  access_valid                       in   1        load/store present in memory stage
//  access_addr                        in   ADDR_W   byte address of the access
//  hit                                in   1        tag compare result for access_addr
//  victim_dirty                       in   1        indexed line is valid and dirty
//  victim_addr                        in   ADDR_W   line address of the victim (from tag)
//  victim_line                        in   LINE_W   victim data from the data array
//  mem_req                            out  1        line request to memory, held until mem_ack
//  mem_we                             out  1        1 = line write, 0 = line read (valid with mem_req)
//  mem_addr                           out  ADDR_W   line-aligned address (low OFFSET_W bits = 0)
//  mem_wdata                          out  LINE_W   writeback data
//  mem_ack                            in   1        one-cycle completion pulse; read data valid with it
//  mem_rdata                          in   LINE_W   refill data
//  refill_we                          out  1        one-cycle write of refill_line + tag into cache
//  refill_line                        out  LINE_W   registered refill data
//  d_cache_miss                       out  1        stall request: miss pending or refill active
//  enable_write_from_cache_to_memory  out  1        stall request: writeback in progress
// BEHAVIOUR
//  Reset: state IDLE; mem_req, mem_we, refill_we, enable_write_... = 0; mem_addr, mem_wdata, refill_line = 0.
//  IDLE: miss = access_valid && !hit. d_cache_miss = miss (combinational, same cycle).
//        On miss: capture line addr of access_addr (miss_addr) and, if victim_dirty, victim_addr/victim_line.
//        Next: victim_dirty ? WB : RD.
//  WB:  mem_req=1, mem_we=1, mem_addr=victim_addr, mem_wdata=captured line.
//       enable_write_... = 1, d_cache_miss = 0. On mem_ack -> RD.
//  RD:  mem_req=1, mem_we=0, mem_addr=miss_addr, d_cache_miss = 1. On mem_ack: register mem_rdata -> FILL.
//  FILL: refill_we=1 for exactly one cycle, d_cache_miss = 1 -> IDLE. The next cycle re-looks-up and must hit.
//  Outputs other than the IDLE d_cache_miss term are registered-state decodes; mem_req drops the cycle after mem_ack.
//  Miss to victim-clean line: latency = 1 (IDLE) + ack wait + 1 (FILL). The WB leg adds its own ack wait.
//  mem_ack while not in WB/RD: ignored. mem_ack in the same cycle mem_req first rises is accepted.
//  access_valid/hit/victim_* are ignored outside IDLE; a flushed instruction (branch/exception) does NOT abort.
//    The memory transaction always completes, and the refill still writes the cache.
//  Stores: write-allocate. The store completes via the normal hit path after FILL.
//  rst_n low mid-transaction: immediate return to IDLE, mem_req=0. The memory model must drop the request.
// CONFIGURATION
//  DCACHE_MISS_STATS_EN defined: adds outputs miss_count[31:0] and writeback_count[31:0], reset 0.
//    miss_count increments on each IDLE->WB/RD transition; writeback_count on each IDLE->WB transition.
//    Both saturate at 32'hFFFF_FFFF.
//  Undefined: ports and counters absent; no other behaviour change.
// STRUCTURE
//  Package dcache_pkg: state encoding (IDLE, WB, RD, FILL as 2-bit localparams).
//    Also holds LINE_W/OFFSET_W helpers and the line_align(addr) function; the cache arrays share it.
//  Sub-module dcache_stat_counter (saturating 32-bit counter), instantiated twice under DCACHE_MISS_STATS_EN.
//  FSM, capture registers and output decode stay in dcache_miss_ctrl.
// TESTING
//  1 hit: access_valid=1, hit=1 -> d_cache_miss=0, mem_req never rises, state stays IDLE.
//  2 clean miss, addr 0x0000_1234, ack 5 cycles after req:
//    mem_addr=0x0000_1230, mem_we=0, d_cache_miss high 7 cycles, refill_we 1 cycle with mem_rdata.
//  3 dirty miss, victim_addr 0x0000_8230: WB phase first (enable_write_...=1, mem_we=1, mem_wdata=victim_line).
//    Then RD of 0x0000_1230. The two stall outputs are never both 1.
//  4 access_valid drops 2 cycles into RD (flush): transaction still completes, refill_we pulses once, back to IDLE.
//  5 rst_n low during WB with mem_req=1: mem_req and enable_write_... go 0 asynchronously; state IDLE after release.
//  6 DCACHE_MISS_STATS_EN: run scenarios 2 then 3 -> miss_count=2, writeback_count=1; stray mem_ack in IDLE changes nothing.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared D-cache definitions: miss-sequencer state encoding, line geometry helpers and line alignment.
// Used by dcache_miss_ctrl and the cache tag/data arrays.
package dcache_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WB   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;
  localparam logic [1:0] ST_FILL = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    WB   = ST_WB,
    RD   = ST_RD,
    FILL = ST_FILL
  } miss_state_e;

  function automatic int calc_line_w(input int line_words, input int data_w);
    return line_words * data_w;
  endfunction

  function automatic int calc_offset_w(input int line_words, input int data_w);
    return $clog2(line_words * data_w / 8);
  endfunction

  // Callers pass their own address width zero-extended to 64 bits and truncate the result.
  function automatic logic [63:0] line_align(input logic [63:0] addr, input int offset_w);
    return addr & ~((64'd1 << offset_w) - 64'd1);
  endfunction

endpackage

// File: rtl/dcache_stat_counter.sv
// Saturating 32-bit event counter for D-cache miss statistics.
module dcache_stat_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/dcache_miss_ctrl.sv
// D-cache miss sequencer: optional dirty-victim writeback, line refill, then stall release.
// Define DCACHE_MISS_STATS_EN to add the miss_count / writeback_count statistics outputs.
module dcache_miss_ctrl
  import dcache_pkg::*;
#(
  parameter  int ADDR_W     = 32,
  parameter  int DATA_W     = 32,
  parameter  int LINE_WORDS = 4,
  localparam int LINE_W     = calc_line_w(LINE_WORDS, DATA_W),
  localparam int OFFSET_W   = calc_offset_w(LINE_WORDS, DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              access_valid,
  input  logic [ADDR_W-1:0] access_addr,
  input  logic              hit,
  input  logic              victim_dirty,
  input  logic [ADDR_W-1:0] victim_addr,
  input  logic [LINE_W-1:0] victim_line,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              refill_we,
  output logic [LINE_W-1:0] refill_line,
  output logic              d_cache_miss,
  output logic              enable_write_from_cache_to_memory
`ifdef DCACHE_MISS_STATS_EN
  ,
  output logic [31:0]       miss_count,
  output logic [31:0]       writeback_count
`endif
);

  miss_state_e       state_q, state_d;
  logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [LINE_W-1:0] refill_line_q, refill_line_d;
  logic              mem_req_q, mem_req_d;
  logic              wb_phase_q, wb_phase_d;
  logic              refill_we_q, refill_we_d;
  logic              miss;

  assign miss = access_valid && !hit;

  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path leaves it unassigned (no latch).
    state_d       = state_q;
    miss_addr_d   = miss_addr_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    refill_line_d = refill_line_q;

    unique case (state_q)
      IDLE: begin
        if (miss) begin
          miss_addr_d = ADDR_W'(line_align(64'(access_addr), OFFSET_W));
          if (victim_dirty) begin
            state_d     = WB;
            mem_addr_d  = ADDR_W'(line_align(64'(victim_addr), OFFSET_W));
            mem_wdata_d = victim_line;
          end else begin
            state_d    = RD;
            mem_addr_d = ADDR_W'(line_align(64'(access_addr), OFFSET_W));
          end
        end
      end
      WB: begin
        if (mem_ack) begin
          state_d    = RD;
          mem_addr_d = miss_addr_q;
        end
      end
      RD: begin
        if (mem_ack) begin
          state_d       = FILL;
          refill_line_d = mem_rdata;
        end
      end
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the flops aligned with the state.
    mem_req_d   = (state_d == WB) || (state_d == RD);
    wb_phase_d  = (state_d == WB);
    refill_we_d = (state_d == FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      miss_addr_q   <= '0;
      mem_addr_q    <= '0;
      // NOTE: the line-wide data registers are reset too, so the memory and cache never see X data.
      mem_wdata_q   <= '0;
      refill_line_q <= '0;
      mem_req_q     <= 1'b0;
      wb_phase_q    <= 1'b0;
      refill_we_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q       <= state_d;
      miss_addr_q   <= miss_addr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      refill_line_q <= refill_line_d;
      mem_req_q     <= mem_req_d;
      wb_phase_q    <= wb_phase_d;
      refill_we_q   <= refill_we_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = wb_phase_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign refill_we   = refill_we_q;
  assign refill_line = refill_line_q;
  assign enable_write_from_cache_to_memory = wb_phase_q;

  // The stall is raised the same cycle a miss is seen; during writeback the other stall line covers it.
  assign d_cache_miss = ((state_q == IDLE) && miss) || (state_q == RD) || (state_q == FILL);

`ifdef DCACHE_MISS_STATS_EN
  logic miss_start;
  logic wb_start;

  assign miss_start = (state_q == IDLE) && miss;
  assign wb_start   = miss_start && victim_dirty;

  dcache_stat_counter u_miss_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss_start),
    .count (miss_count)
  );

  dcache_stat_counter u_writeback_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wb_start),
    .count (writeback_count)
  );
`endif

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Randomized self-checking bench for dcache_miss_ctrl against a per-transaction timeline model.
module tb_dcache_miss_ctrl;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;
  localparam int LINE_BYTES = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              access_valid;
  logic [ADDR_W-1:0] access_addr;
  logic              hit;
  logic              victim_dirty;
  logic [ADDR_W-1:0] victim_addr;
  logic [LINE_W-1:0] victim_line;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [LINE_W-1:0] mem_rdata;
  logic              refill_we;
  logic [LINE_W-1:0] refill_line;
  logic              d_cache_miss;
  logic              enable_write_from_cache_to_memory;
`ifdef DCACHE_MISS_STATS_EN
  logic [31:0]       miss_count;
  logic [31:0]       writeback_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned exp_miss = 0;
  int unsigned exp_wb   = 0;

  dcache_miss_ctrl dut (
    .clk                               (clk),
    .rst_n                             (rst_n),
    .access_valid                      (access_valid),
    .access_addr                       (access_addr),
    .hit                               (hit),
    .victim_dirty                      (victim_dirty),
    .victim_addr                       (victim_addr),
    .victim_line                       (victim_line),
    .mem_req                           (mem_req),
    .mem_we                            (mem_we),
    .mem_addr                          (mem_addr),
    .mem_wdata                         (mem_wdata),
    .mem_ack                           (mem_ack),
    .mem_rdata                         (mem_rdata),
    .refill_we                         (refill_we),
    .refill_line                       (refill_line),
    .d_cache_miss                      (d_cache_miss),
    .enable_write_from_cache_to_memory (enable_write_from_cache_to_memory)
`ifdef DCACHE_MISS_STATS_EN
    ,
    .miss_count                        (miss_count),
    .writeback_count                   (writeback_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] line_base(input logic [31:0] a);
    return (a / LINE_BYTES) * LINE_BYTES;
  endfunction

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_stats(input string tag);
`ifdef DCACHE_MISS_STATS_EN
    check({tag, "_miss_count"}, 128'(miss_count), 128'(exp_miss));
    check({tag, "_wb_count"}, 128'(writeback_count), 128'(exp_wb));
`endif
  endtask

  // IDLE cycles with no miss presented: either no access or a hit; stray acks must be ignored.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      access_addr  = $urandom;
      access_valid = 1'($urandom);
      hit          = access_valid ? 1'b1 : 1'($urandom);
      victim_dirty = 1'($urandom);
      victim_addr  = $urandom;
      victim_line  = rand_line();
      mem_ack      = 1'($urandom);
      mem_rdata    = rand_line();
      #1;
      check("idle_mem_req", 128'(mem_req), 128'(0));
      check("idle_d_cache_miss", 128'(d_cache_miss), 128'(0));
      check("idle_wb_stall", 128'(enable_write_from_cache_to_memory), 128'(0));
      check("idle_refill_we", 128'(refill_we), 128'(0));
    end
    mem_ack = 1'b0;
  endtask

  // One miss: cycle 0 presents it, then wb_wait WB cycles (if dirty), rd_wait RD cycles,
  // one FILL cycle and a final re-lookup cycle that hits.
  task automatic run_miss(input logic [31:0] addr, input bit dirty, input logic [31:0] vaddr,
                          input logic [127:0] vline, input logic [127:0] rdata,
                          input int wb_wait, input int rd_wait, input bit flush);
    int  w;
    int  last;
    int  stall_seen;
    bit  is_wb, is_rd, is_fill, is_post;
    w          = dirty ? wb_wait : 0;
    last       = w + rd_wait + 2;
    stall_seen = 0;
    for (int t = 0; t <= last; t++) begin
      @(negedge clk);
      is_wb   = dirty && (t >= 1) && (t <= w);
      is_rd   = (t >= w + 1) && (t <= w + rd_wait);
      is_fill = (t == w + rd_wait + 1);
      is_post = (t == last);
      if (t == 0) begin
        access_valid = 1'b1;
        access_addr  = addr;
        hit          = 1'b0;
        victim_dirty = dirty;
        victim_addr  = vaddr;
        victim_line  = vline;
      end else begin
        access_addr  = $urandom;
        hit          = 1'($urandom);
        victim_dirty = 1'($urandom);
        victim_addr  = $urandom;
        victim_line  = rand_line();
        access_valid = (flush && (t >= w + 3)) ? 1'b0 : 1'($urandom);
      end
      if (is_post) begin
        access_valid = !flush;
        access_addr  = addr;
        hit          = 1'b1;
      end
      mem_ack   = (is_wb && (t == w)) || (is_rd && (t == w + rd_wait)) ||
                  ((t == 0 || is_fill || is_post) && 1'($urandom));
      mem_rdata = (is_rd && (t == w + rd_wait)) ? rdata : rand_line();
      #1;
      check("mem_req", 128'(mem_req), 128'(is_wb || is_rd));
      check("mem_we", 128'(mem_we), 128'(is_wb));
      check("wb_stall", 128'(enable_write_from_cache_to_memory), 128'(is_wb));
      check("d_cache_miss", 128'(d_cache_miss), 128'((t == 0) || is_rd || is_fill));
      check("refill_we", 128'(refill_we), 128'(is_fill));
      if (is_wb) begin
        check("wb_mem_addr", 128'(mem_addr), 128'(line_base(vaddr)));
        check("wb_mem_wdata", mem_wdata, vline);
      end
      if (is_rd) check("rd_mem_addr", 128'(mem_addr), 128'(line_base(addr)));
      if (is_fill) check("refill_line", refill_line, rdata);
      if (d_cache_miss && enable_write_from_cache_to_memory) check("stalls_exclusive", 128'(1), 128'(0));
      if (d_cache_miss) stall_seen++;
    end
    mem_ack = 1'b0;
    check("stall_cycles", 128'(stall_seen), 128'(rd_wait + 2));
    exp_miss++;
    if (dirty) exp_wb++;
  endtask

  initial begin
    rst_n        = 1'b0;
    access_valid = 1'b0;
    access_addr  = '0;
    hit          = 1'b0;
    victim_dirty = 1'b0;
    victim_addr  = '0;
    victim_line  = '0;
    mem_ack      = 1'b0;
    mem_rdata    = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", 128'(mem_req), 128'(0));
    check("rst_mem_we", 128'(mem_we), 128'(0));
    check("rst_refill_we", 128'(refill_we), 128'(0));
    check("rst_wb_stall", 128'(enable_write_from_cache_to_memory), 128'(0));
    check("rst_mem_addr", 128'(mem_addr), 128'(0));
    check("rst_mem_wdata", mem_wdata, 128'(0));
    check("rst_refill_line", refill_line, 128'(0));
    check_stats("rst");
    rst_n = 1'b1;

    // Hits and idle traffic never start a transaction.
    idle_cycles(6);

    // Clean miss at 0x1234, ack in the fifth request cycle: seven stall cycles.
    run_miss(32'h0000_1234, 1'b0, 32'h0, rand_line(), 128'hA5A5_0001_0002_0003_0004_0005_0006_0007,
             0, 5, 1'b0);
    idle_cycles(2);
    // Dirty miss: writeback of victim 0x8230 first, then refill of 0x1230.
    run_miss(32'h0000_1234, 1'b1, 32'h0000_8230, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE,
             128'h1111_2222_3333_4444_5555_6666_7777_8888, 3, 2, 1'b0);
    check_stats("after_2_3");
    // Stray acks in IDLE leave state and counters untouched.
    idle_cycles(4);
    check_stats("stray_ack");

    // Flush two cycles into RD: transaction still completes with a single refill.
    run_miss(32'h0000_40F8, 1'b0, 32'h0, rand_line(), rand_line(), 0, 5, 1'b1);
    run_miss(32'h0000_7777, 1'b1, 32'h0000_9990, rand_line(), rand_line(), 2, 4, 1'b1);
    idle_cycles(1);

    // Ack in the same cycle the request first rises.
    run_miss($urandom, 1'b1, $urandom, rand_line(), rand_line(), 1, 1, 1'b0);

    for (int k = 0; k < 20; k++) begin
      run_miss($urandom, 1'($urandom), $urandom, rand_line(), rand_line(),
               $urandom_range(1, 6), $urandom_range(1, 6), 1'($urandom));
      idle_cycles($urandom_range(0, 3));
    end
    check_stats("random");

    // Reset during writeback: request and writeback stall drop without a clock edge.
    @(negedge clk);
    access_valid = 1'b1;
    access_addr  = 32'h0000_1234;
    hit          = 1'b0;
    victim_dirty = 1'b1;
    victim_addr  = 32'h0000_8230;
    victim_line  = rand_line();
    mem_ack      = 1'b0;
    @(negedge clk);
    access_valid = 1'b0;
    #1;
    check("wb_before_rst_req", 128'(mem_req), 128'(1));
    check("wb_before_rst_stall", 128'(enable_write_from_cache_to_memory), 128'(1));
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_mem_req", 128'(mem_req), 128'(0));
    check("async_rst_wb_stall", 128'(enable_write_from_cache_to_memory), 128'(0));
    check("async_rst_d_cache_miss", 128'(d_cache_miss), 128'(0));
    exp_miss = 0;
    exp_wb   = 0;
    check_stats("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(3);
    run_miss(32'h0000_0010, 1'b0, 32'h0, rand_line(), rand_line(), 0, 2, 1'b0);
    check_stats("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
